sha256_core_mb: RTL

Next-generation SHA-256 compression engine with a byte-wide register interface.
- Adds a parametrised number of rounds per clock and multi-block chaining, so messages longer than one block can be hashed.
- Adds a maskable, clearable interrupt and a message buffer that stays stable while the engine runs.
- Sits behind the SPI byte bridge: the host writes a padded 512-bit block, starts it, polls or waits for IRQ, then reads the 256-bit digest.

---
 rtl/sha256_pkg.sv | 70 +++++++
 rtl/sha256_round.sv | 34 +++
 rtl/sha256_core_mb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and round helpers for the multi-block SHA-256 engine.
// Working variables and schedule windows are packed so they chain through ports.
package sha256_pkg;

  typedef logic [7:0][31:0]  vars_t;
  typedef logic [15:0][31:0] win_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam logic [6:0] ADDR_WHO     = 7'd64;
  localparam logic [6:0] ADDR_CTRL    = 7'd65;
  localparam logic [6:0] ADDR_REV     = 7'd66;
  localparam logic [6:0] ADDR_DIG     = 7'd70;
  localparam logic [6:0] ADDR_DIG_END = 7'd101;

  localparam int CTRL_START = 0;
  localparam int CTRL_CHAIN = 1;
  localparam int CTRL_IRQ   = 2;
  localparam int CTRL_CLR   = 3;

  // Index 0 holds H0 / variable a
  localparam vars_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one message-schedule step.
// The window holds W[t..t+15]; W[t] is consumed and W[t+16] appended.
module sha256_round
  import sha256_pkg::*;
(
  input  vars_t       i_vars,
  input  win_t        i_win,
  input  logic [31:0] i_kt,
  output vars_t       o_vars,
  output win_t        o_win
);

  logic [31:0] t1, t2, ch, maj;

  always_comb begin
    ch  = (i_vars[4] & i_vars[5]) ^ (~i_vars[4] & i_vars[6]);
    maj = (i_vars[0] & i_vars[1]) ^ (i_vars[0] & i_vars[2])
        ^ (i_vars[1] & i_vars[2]);
    t1  = i_vars[7] + bsig1(i_vars[4]) + ch + i_kt + i_win[0];
    t2  = bsig0(i_vars[0]) + maj;
    o_vars[0] = t1 + t2;
    o_vars[1] = i_vars[0];
    o_vars[2] = i_vars[1];
    o_vars[3] = i_vars[2];
    o_vars[4] = i_vars[3] + t1;
    o_vars[5] = i_vars[4];
    o_vars[6] = i_vars[5];
    o_vars[7] = i_vars[6];
    o_win[14:0] = i_win[15:1];
    o_win[15]   = ssig1(i_win[14]) + i_win[9]
                + ssig0(i_win[1]) + i_win[0];
  end

endmodule

// File: rtl/sha256_core_mb.sv
// Byte-register SHA-256 engine: N rounds per clock, chaining, maskable IRQ.
// Hashing runs on a shadow window so the host buffer may be refilled meanwhile.
module sha256_core_mb
  import sha256_pkg::*;
#(
  parameter int         ROUNDS_PER_CYCLE = 1,
  parameter logic [7:0] WHO_AM_I_VAL     = 8'h08,
  parameter logic [7:0] REVISION_VAL     = 8'd60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_w_addr,
  input  logic [7:0] i_data8,
  input  logic       i_we,
  output logic [7:0] o_data_mux,
  output logic       o_irq
);

  localparam int R = ROUNDS_PER_CYCLE;

  state_e           state_q, state_d;
  logic [63:0][7:0] blk_q, blk_d;
  vars_t            digest_q, digest_d;
  vars_t            hin_q, hin_d;
  vars_t            vars_q, vars_d;
  win_t             win_q, win_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             chain_q, chain_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;

  win_t             win_ld;
  vars_t [R:0]      v_ch;
  win_t  [R:0]      w_ch;
  logic             ctrl_we, busy;
  logic [4:0]       didx;
  logic [31:0]      dword;

  for (genvar i = 0; i < 16; i++) begin : g_ld
    assign win_ld[i] = {blk_q[4*i], blk_q[4*i+1],
                        blk_q[4*i+2], blk_q[4*i+3]};
  end

  assign v_ch[0] = vars_q;
  assign w_ch[0] = win_q;

  // Round u of this cycle is absolute round cnt_q + u
  for (genvar u = 0; u < R; u++) begin : g_rnd
    sha256_round u_rnd (
      .i_vars (v_ch[u]),
      .i_win  (w_ch[u]),
      .i_kt   (K[cnt_q[5:0] + 6'(u)]),
      .o_vars (v_ch[u+1]),
      .o_win  (w_ch[u+1])
    );
  end

  assign busy    = state_q != ST_IDLE;
  assign ctrl_we = i_we && (i_w_addr == ADDR_CTRL);
  assign o_irq   = done_q & irq_en_q;

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    digest_d = digest_q;
    hin_d    = hin_q;
    vars_d   = vars_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (i_we && !i_w_addr[6]) blk_d[i_w_addr[5:0]] = i_data8;
    if (ctrl_we) begin
      irq_en_d = i_data8[CTRL_IRQ];
      if (i_data8[CTRL_CLR]) done_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_we && i_data8[CTRL_START]) begin
          chain_d = i_data8[CTRL_CHAIN];
          hin_d   = i_data8[CTRL_CHAIN] ? digest_q : IV;
          vars_d  = hin_d;
          win_d   = win_ld;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (cnt_q[6]) begin
          state_d = ST_FINAL;
        end else begin
          vars_d = v_ch[R];
          win_d  = w_ch[R];
          cnt_d  = cnt_q + 7'(R);
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) digest_d[i] = vars_q[i] + hin_q[i];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    didx       = 5'(i_w_addr - ADDR_DIG);
    dword      = digest_q[didx[4:2]];
    o_data_mux = 8'hAA;
    unique case (1'b1)
      !i_w_addr[6]:
        o_data_mux = blk_q[i_w_addr[5:0]];
      i_w_addr == ADDR_WHO:
        o_data_mux = WHO_AM_I_VAL;
      i_w_addr == ADDR_CTRL:
        o_data_mux = {2'b00, state_q, done_q, irq_en_q, chain_q, busy};
      i_w_addr == ADDR_REV:
        o_data_mux = REVISION_VAL;
      (i_w_addr >= ADDR_DIG) && (i_w_addr <= ADDR_DIG_END):
        o_data_mux = 8'(dword >> {~didx[1:0], 3'b000});
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      blk_q    <= '0;
      digest_q <= IV;
      hin_q    <= '0;
      vars_q   <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      chain_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      digest_q <= digest_d;
      hin_q    <= hin_d;
      vars_q   <= vars_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

endmodule
